// File: rtl/instr_mem_pkg.sv
// ----------------------------------------------------------------------------
// instr_mem_pkg
//   Shared constants, FSM encoding and the bundle word selector used by the
//   instruction-RAM write sequencer and its bundle buffer.
//   No ports (package).
// ----------------------------------------------------------------------------
package instr_mem_pkg;

  localparam int WORD_W    = 32;
  localparam int MAX_WORDS = 6;
  localparam int QTY_W     = 3;
  localparam int ADDR_W    = 10;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int BUNDLE_W  = WORD_W * MAX_WORDS;

  // Sized copies so comparisons against narrow registers stay width-exact.
  localparam logic [QTY_W-1:0]  QTY_MAX   = QTY_W'(MAX_WORDS);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  // Word idx of a packed bundle (word k lives in bits [32k+31:32k]).
  // Indices beyond the last word return zero.
  function automatic logic [WORD_W-1:0] word_sel(
    input logic [BUNDLE_W-1:0] bundle,
    input logic [QTY_W-1:0]    idx
  );
    logic [WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < MAX_WORDS; k++) begin
      if (idx == QTY_W'(k)) begin
        w = bundle[k*WORD_W +: WORD_W];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/instr_bundle_buf.sv
// ----------------------------------------------------------------------------
// instr_bundle_buf
//   Holds an accepted instruction bundle for the duration of its burst and
//   presents the word selected by the write index.
//   Ports:
//     clk      in   clock, rising edge
//     rst_n    in   asynchronous active-low reset
//     i_load   in   capture i_bundle on this edge
//     i_bundle in   packed bundle, word k in bits [32k+31:32k]
//     i_idx    in   word index to present
//     o_word   out  selected word (combinational from the capture register)
// ----------------------------------------------------------------------------
module instr_bundle_buf
  import instr_mem_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic [BUNDLE_W-1:0] i_bundle,
  input  logic [QTY_W-1:0]    i_idx,
  output logic [WORD_W-1:0]   o_word
);

  logic [BUNDLE_W-1:0] r_bundle;

  // Captured once at acceptance so the loader may change its inputs freely
  // while the burst is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bundle <= '0;
    end else if (i_load) begin
      r_bundle <= i_bundle;
    end
  end

  assign o_word = word_sel(r_bundle, i_idx);

endmodule

// File: rtl/instr_write_sequencer.sv
// ----------------------------------------------------------------------------
// instr_write_sequencer
//   Accepts a bundle of 1..6 instructions over valid/ready and writes it to a
//   single-port instruction RAM, one word per cycle, at an auto-incrementing
//   cursor. Tracks fill level, rejects malformed/overflowing bundles.
//   Ports:
//     clk, rst_n        clock / asynchronous active-low reset
//     clear             rewind cursor and fill (honoured in IDLE only)
//     in_valid/in_ready bundle handshake
//     in_instructions   packed bundle, word k in bits [32k+31:32k]
//     in_quantity       number of valid words (legal 1..6)
//     mem_we/addr/wdata RAM write port (addr/wdata zero when not writing)
//     cursor            next address to be written
//     fill              words written since reset/clear (0..1024)
//     full              fill == DEPTH
//     busy              burst in progress
//     done              pulse on the last write of a bundle
//     err_qty, err_ovf  one-cycle rejection pulses
// ----------------------------------------------------------------------------
module instr_write_sequencer
  import instr_mem_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BUNDLE_W-1:0] in_instructions,
  input  logic [QTY_W-1:0]    in_quantity,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic [ADDR_W-1:0]   cursor,
  output logic [ADDR_W:0]     fill,
  output logic                full,
  output logic                busy,
  output logic                done,
  output logic                err_qty,
  output logic                err_ovf
);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_cursor;
  logic [ADDR_W:0]   r_fill;
  logic [QTY_W-1:0]  r_idx;
  logic [QTY_W-1:0]  r_qty;
  logic              r_err_qty;
  logic              r_err_ovf;

  logic              w_idle;
  logic              w_accept;
  logic              w_qty_bad;
  logic              w_qty_ovf;
  logic              w_start;
  logic              w_last;
  logic [ADDR_W:0]   w_room;
  logic [WORD_W-1:0] w_word;

  assign w_idle    = (r_state == IDLE);
  // rst_n is folded in so the handshake stays closed while reset is held.
  assign in_ready  = rst_n & w_idle & ~clear;
  assign w_accept  = in_valid & in_ready;

  assign w_qty_bad = (in_quantity == '0) || (in_quantity > QTY_MAX);
  assign w_room    = DEPTH_CNT - r_fill;
  assign w_qty_ovf = {{(ADDR_W+1-QTY_W){1'b0}}, in_quantity} > w_room;
  assign w_start   = w_accept & ~w_qty_bad & ~w_qty_ovf;

  assign w_last    = (r_state == WRITE) && (r_idx == r_qty - QTY_W'(1));

  instr_bundle_buf u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_start),
    .i_bundle (in_instructions),
    .i_idx    (r_idx),
    .o_word   (w_word)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = WRITE;
      WRITE:   if (w_last)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------- cursor / fill / index / error pulses ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cursor  <= '0;
      r_fill    <= '0;
      r_idx     <= '0;
      r_qty     <= '0;
      r_err_qty <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      // A rejected bundle is consumed, so the loader never stalls on a
      // full RAM; quantity errors take priority over overflow.
      r_err_qty <= w_accept & w_qty_bad;
      r_err_ovf <= w_accept & ~w_qty_bad & w_qty_ovf;
      if (r_state == IDLE) begin
        if (clear) begin
          r_cursor <= '0;
          r_fill   <= '0;
        end else if (w_start) begin
          r_qty <= in_quantity;
          r_idx <= '0;
        end
      end else begin
        // Cursor wraps naturally at DEPTH; fill accounting prevents overrun.
        r_cursor <= r_cursor + ADDR_W'(1);
        r_fill   <= r_fill + (ADDR_W+1)'(1);
        r_idx    <= r_idx + QTY_W'(1);
      end
    end
  end

  // ---------------- FSM: outputs (decoded from registers) ----------------
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    if (r_state == WRITE) begin
      mem_we    = 1'b1;
      mem_addr  = r_cursor;
      mem_wdata = w_word;
      done      = w_last;
    end
  end

  assign busy    = (r_state == WRITE);
  assign cursor  = r_cursor;
  assign fill    = r_fill;
  assign full    = (r_fill == DEPTH_CNT);
  assign err_qty = r_err_qty;
  assign err_ovf = r_err_ovf;

endmodule

// File: tb/tb_instr_write_sequencer.sv
module tb_instr_write_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [191:0] in_instructions;
  logic [2:0]   in_quantity;
  logic         mem_we;
  logic [9:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic [9:0]   cursor;
  logic [10:0]  fill;
  logic         full;
  logic         busy;
  logic         done;
  logic         err_qty;
  logic         err_ovf;

  instr_write_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (clear),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instructions (in_instructions),
    .in_quantity     (in_quantity),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .cursor          (cursor),
    .fill            (fill),
    .full            (full),
    .busy            (busy),
    .done            (done),
    .err_qty         (err_qty),
    .err_ovf         (err_ovf)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_writes = 0;
  bit cmp_en   = 1'b0;

  // ---------------- reference model ----------------
  // Pending writes of the accepted bundle, front = write shown this cycle.
  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    bit          last;
  } wr_t;
  wr_t q[$];
  int  m_cur  = 0;   // cursor once every queued write has landed
  int  m_fill = 0;   // fill once every queued write has landed
  bit  exp_eq = 1'b0;
  bit  exp_eo = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    bit idle;
    bit acc;
    int qn;
    wr_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_cur = 0; m_fill = 0; exp_eq = 1'b0; exp_eo = 1'b0;
      end else begin
        idle   = (q.size() == 0);
        acc    = idle && !clear && in_valid;
        qn     = int'(in_quantity);
        exp_eq = 1'b0;
        exp_eo = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        if (idle && clear) begin
          m_cur = 0; m_fill = 0;
        end else if (acc) begin
          if (qn < 1 || qn > 6) exp_eq = 1'b1;
          else if (qn > 1024 - m_fill) exp_eo = 1'b1;
          else begin
            for (int k = 0; k < qn; k++) begin
              e.addr = 10'((m_cur + k) % 1024);
              e.data = in_instructions[k*32 +: 32];
              e.last = (k == qn - 1);
              q.push_back(e);
            end
            m_cur  = (m_cur + qn) % 1024;
            m_fill = m_fill + qn;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    bit   we;
    int   f;
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) n_writes++;
      if (cmp_en) begin
        we = (q.size() > 0);
        f  = m_fill - q.size();
        check("mem_we",   64'(mem_we),    64'(we));
        check("mem_addr", 64'(mem_addr),  we ? 64'(q[0].addr) : 64'd0);
        check("mem_wdata",64'(mem_wdata), we ? 64'(q[0].data) : 64'd0);
        check("done",     64'(done),      we ? 64'(q[0].last) : 64'd0);
        check("cursor",   64'(cursor),    we ? 64'(q[0].addr) : 64'(m_cur));
        check("fill",     64'(fill),      64'(f));
        check("full",     64'(full),      64'(f == 1024));
        check("busy",     64'(busy),      64'(we));
        check("err_qty",  64'(err_qty),   64'(exp_eq));
        check("err_ovf",  64'(err_ovf),   64'(exp_eo));
        check("in_ready", 64'(in_ready),  64'(rst_n && !we && !clear));
      end
    end
  end

  // ---------------- stimulus helpers (call at posedge+1) ----------------
  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic send(input int qty, input logic [191:0] b, output int waited);
    bit got;
    in_valid = 1'b1; in_quantity = 3'(qty); in_instructions = b;
    waited = 0; got = 1'b0;
    while (!got && waited <= 200) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      n_assert++; n_fail++;
      $display("FAIL handshake_timeout: got no ready expected ready within 200 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_quantity = 3'($urandom);
    for (int k = 0; k < 6; k++) in_instructions[k*32 +: 32] = $urandom;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (!busy && in_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_assert++; n_fail++;
      $display("FAIL idle_timeout: got busy expected idle within 50 cycles");
    end
    align();
  endtask

  task automatic do_clear();
    align(); clear = 1'b1;
    align(); clear = 1'b0;
  endtask

  function automatic logic [191:0] rand_bundle();
    logic [191:0] b;
    for (int k = 0; k < 6; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [191:0] b;
    int w;
    int wr0;
    int qty;
    clear = 1'b0; in_valid = 1'b0; in_quantity = '0; in_instructions = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_mem_we",   64'(mem_we),   64'd0);
    cmp_en = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(in_ready), 64'd1);
    check("post_rst_fill",  64'(fill),     64'd0);
    align();

    // qty=2 first bundle
    b = '0; b[31:0] = 32'hA0000001; b[63:32] = 32'hA0000002;
    send(2, b, w);
    @(negedge clk);
    check("t1_w0_addr", 64'(mem_addr),  64'd0);
    check("t1_w0_data", 64'(mem_wdata), 64'hA0000001);
    @(negedge clk);
    check("t1_w1_addr", 64'(mem_addr),  64'd1);
    check("t1_w1_data", 64'(mem_wdata), 64'hA0000002);
    check("t1_done",    64'(done),      64'd1);
    @(negedge clk);
    check("t1_cursor",  64'(cursor),    64'd2);
    check("t1_fill",    64'(fill),      64'd2);
    align();

    // qty=6 then back-to-back qty=1
    do_clear();
    for (int k = 0; k < 6; k++) b[k*32 +: 32] = 32'h10 + 32'(k);
    send(6, b, w);
    b = rand_bundle(); b[31:0] = 32'h99;
    send(1, b, w);
    check("t2_ready_low_cycles", 64'(w), 64'd6);
    @(negedge clk);
    check("t2_b2b_addr", 64'(mem_addr),  64'd6);
    check("t2_b2b_data", 64'(mem_wdata), 64'h99);
    wait_idle();

    // illegal quantities
    send(0, rand_bundle(), w);
    @(negedge clk);
    check("t3_q0_err_qty", 64'(err_qty), 64'd1);
    align();
    send(7, rand_bundle(), w);
    @(negedge clk);
    check("t3_q7_err_qty", 64'(err_qty), 64'd1);
    check("t3_q7_err_ovf", 64'(err_ovf), 64'd0);
    check("t3_cursor",     64'(cursor),  64'd7);
    align();

    // fill to 1020, then overflow / exact fill
    do_clear();
    for (int i = 0; i < 170; i++) send(6, rand_bundle(), w);
    wait_idle();
    check("t4_fill1020", 64'(fill), 64'd1020);
    send(5, rand_bundle(), w);
    @(negedge clk);
    check("t4_q5_err_ovf", 64'(err_ovf), 64'd1);
    check("t4_q5_fill",    64'(fill),    64'd1020);
    align();
    send(4, rand_bundle(), w);
    wait_idle();
    check("t4_full",   64'(full),   64'd1);
    check("t4_cursor", 64'(cursor), 64'd0);
    check("t4_fill",   64'(fill),   64'd1024);
    send(1, rand_bundle(), w);
    @(negedge clk);
    check("t4_q1_err_ovf", 64'(err_ovf), 64'd1);
    align();

    // clear during a burst
    do_clear();
    wr0 = n_writes;
    send(4, rand_bundle(), w);
    align();
    clear = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_writes",   64'(n_writes - wr0), 64'd4);
    check("t5_cursor",   64'(cursor),   64'd0);
    check("t5_fill",     64'(fill),     64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd0);
    align();
    clear = 1'b0;

    // async reset in the middle of a burst
    send(5, rand_bundle(), w);
    align();
    #1 rst_n = 1'b0;
    #1;
    check("t6_mem_we", 64'(mem_we), 64'd0);
    check("t6_cursor", 64'(cursor), 64'd0);
    check("t6_fill",   64'(fill),   64'd0);
    check("t6_busy",   64'(busy),   64'd0);
    wr0 = n_writes;
    align(); align();
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t6_no_writes", 64'(n_writes - wr0), 64'd0);
    check("t6_ready",     64'(in_ready),       64'd1);
    align();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 14) == 0) do_clear();
      repeat ($urandom_range(0, 2)) align();
      qty = ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) * 7) : $urandom_range(1, 6);
      send(qty, rand_bundle(), w);
    end
    wait_idle();
    repeat (2) align();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
